rv_branch_predictor: RTL



---
 rtl/rv_pkg.sv | 32 +++
 rtl/rv_bp_sat_counter.sv | 19 +
 rtl/rv_branch_predictor.sv | 119 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: XLEN, branch func3 codes and branch predictor types.
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } func3_branch_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e BP_CTR_RST = WNT;

    // tag is stored right-aligned; bits above the real tag width stay zero
    typedef struct packed {
        logic              valid;
        logic [XLEN-3:0]   tag;
        logic [XLEN-3:0]   target;
        bp_ctr_e           ctr;
    } bp_entry_t;

endpackage

// File: rtl/rv_bp_sat_counter.sv
// Combinational next-state of a 2-bit saturating branch counter.
module rv_bp_sat_counter
    import rv_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/rv_branch_predictor.sv
// Direct-mapped 2-bit counter + BTB branch predictor with EX-side mispredict detection.
// Optional gshare indexing is enabled by defining RV_BP_GSHARE_EN.
module rv_branch_predictor
    import rv_pkg::*;
#(
    parameter  int BP_ENTRIES = 64,
    parameter  int GHR_W      = 6,
    localparam int IDX_W      = $clog2(BP_ENTRIES)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN-1:0]   i_bp_if_pc,
    output logic              o_bp_pred_taken,
    output logic [XLEN-1:0]   o_bp_pred_pc,
    output logic [IDX_W-1:0]  o_bp_pred_idx,
    input  logic              i_bp_upd_valid,
    input  logic [XLEN-1:0]   i_bp_upd_pc,
    input  logic [IDX_W-1:0]  i_bp_upd_idx,
    input  logic              i_bp_upd_taken,
    input  logic [XLEN-1:0]   i_bp_upd_target,
    input  logic              i_bp_upd_pred_taken,
    input  logic [XLEN-1:0]   i_bp_upd_pred_pc,
    output logic              o_bp_mispredict,
    output logic [XLEN-1:0]   o_bp_redirect_pc
);

    if (GHR_W < 2 || GHR_W > IDX_W) begin : g_ghr_w_check
        $error("GHR_W must be in [2, IDX_W]");
    end

    function automatic logic [XLEN-3:0] tag_of(input logic [XLEN-1:0] pc);
        tag_of = (XLEN-2)'(pc >> (IDX_W + 2));
    endfunction

    bp_entry_t        table_q [BP_ENTRIES];
    bp_entry_t        table_d [BP_ENTRIES];
    logic [IDX_W-1:0] lk_idx;
    bp_entry_t        lk_ent;
    logic             lk_hit;
    bp_entry_t        up_ent;
    bp_entry_t        new_ent;
    logic             up_hit;
    logic [1:0]       ctr_nxt;

`ifdef RV_BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (i_bp_upd_valid) ghr_d = {ghr_q[GHR_W-2:0], i_bp_upd_taken};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign lk_idx = i_bp_if_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
`else
    assign lk_idx = i_bp_if_pc[IDX_W+1:2];
`endif

    // Lookup sees only registered state, so a same-cycle update is not bypassed
    always_comb begin
        lk_ent          = table_q[lk_idx];
        lk_hit          = lk_ent.valid && (lk_ent.tag == tag_of(i_bp_if_pc));
        o_bp_pred_taken = lk_hit && lk_ent.ctr[1];
        o_bp_pred_idx   = lk_idx;
        o_bp_pred_pc    = o_bp_pred_taken ? {lk_ent.target, 2'b00} : i_bp_if_pc + XLEN'(4);
    end

    assign up_ent = table_q[i_bp_upd_idx];
    assign up_hit = up_ent.valid && (up_ent.tag == tag_of(i_bp_upd_pc));

    rv_bp_sat_counter u_sat_counter (
        .i_ctr   (up_ent.ctr),
        .i_taken (i_bp_upd_taken),
        .o_ctr   (ctr_nxt)
    );

    always_comb begin
        new_ent = up_ent;
        if (up_hit) begin
            new_ent.ctr = bp_ctr_e'(ctr_nxt);
            if (i_bp_upd_taken) new_ent.target = i_bp_upd_target[XLEN-1:2];
        end else begin
            new_ent.valid  = 1'b1;
            new_ent.tag    = tag_of(i_bp_upd_pc);
            new_ent.target = i_bp_upd_target[XLEN-1:2];
            new_ent.ctr    = i_bp_upd_taken ? WT : WNT;
        end
        table_d = table_q;
        if (i_bp_upd_valid) table_d[i_bp_upd_idx] = new_ent;
    end

    // Tag and target are deliberately left out of reset; valid=0 masks them
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BP_ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= BP_CTR_RST;
            end
        end else begin
            table_q <= table_d;
        end
    end

    always_comb begin
        o_bp_mispredict = 1'b0;
        if (i_bp_upd_valid) begin
            o_bp_mispredict = (i_bp_upd_taken != i_bp_upd_pred_taken) ||
                              (i_bp_upd_taken && i_bp_upd_pred_taken &&
                               (i_bp_upd_pred_pc != i_bp_upd_target));
        end
        o_bp_redirect_pc = i_bp_upd_taken ? i_bp_upd_target : i_bp_upd_pc + XLEN'(4);
    end

endmodule
